// File: rtl/conv_window_gen_pkg.sv
// Shared defaults, FSM state encoding and window indexing helper for the
// conv window generator.
//
// Contents:
//   DEF_WIDTH / DEF_F / DEF_CIN / DEF_IMG_W / DEF_IMG_H : default parameters
//   state_e                                             : FILL / RUN / DONE
//   win_idx(c, r, k, f)                                 : flat index of window entry
package conv_window_gen_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_F     = 5;
    localparam int DEF_CIN   = 3;
    localparam int DEF_IMG_W = 32;
    localparam int DEF_IMG_H = 32;

    typedef enum logic [1:0] {
        FILL = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Position of channel c, window row r (0 = top), window col k (0 = left)
    // in the flat array the neuron layer consumes.
    function automatic int win_idx(input int c, input int r, input int k,
                                   input int f = DEF_F);
        return c * f * f + r * f + k;
    endfunction

endpackage

// File: rtl/conv_window_gen_if.sv
// Stream-in / window-out bundle of the conv window generator.
//
// Signals:
//   in_valid, in_ready, in_pix      : raster-order pixel stream, CIN channels packed
//   win_valid, win_ready, win       : FxF window per channel, flat unpacked array
//   frame_done                      : one-cycle end-of-frame pulse
// Modports:
//   master : pixel source / window consumer side
//   slave  : the window generator itself
interface conv_window_gen_if
    import conv_window_gen_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int F     = DEF_F,
    parameter int CIN   = DEF_CIN
);

    logic                   in_valid;
    logic                   in_ready;
    logic [WIDTH*CIN-1:0]   in_pix;
    logic                   win_valid;
    logic                   win_ready;
    logic [WIDTH-1:0]       win [CIN*F*F];
    logic                   frame_done;

    modport master (
        output in_valid, in_pix, win_ready,
        input  in_ready, win_valid, win, frame_done
    );

    modport slave (
        input  in_valid, in_pix, win_ready,
        output in_ready, win_valid, win, frame_done
    );

endinterface

// File: rtl/conv_window_gen_line_buffer.sv
// One image row of delay: dout is the sample written DEPTH enabled cycles
// ago. Chained F-1 times to give the vertical taps of the window.
//
// Ports:
//   clk   : clock
//   rst_n : synchronous active-low reset (pointer only, storage untouched)
//   en    : advance one sample
//   din   : sample entering the line
//   dout  : sample leaving the line (valid before the write on the same edge)
module conv_window_gen_line_buffer #(
    parameter int DEPTH  = 32,
    parameter int DATA_W = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     ptr;

    // Circular buffer: the slot about to be overwritten holds the oldest sample.
    assign dout = mem[ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (en) begin
            ptr <= (ptr == PW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            mem[ptr] <= din;
        end
    end

endmodule

// File: rtl/conv_window_gen.sv
// Streaming producer for the conv neuron layer: buffers F-1 rows of a
// raster pixel stream and emits every valid FxF window (stride 1, no pad)
// as a flat array, held under valid/ready until taken.
//
// Ports:
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : conv_window_gen_if.slave (pixel in, window out, frame_done)
module conv_window_gen
    import conv_window_gen_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int F     = DEF_F,
    parameter int CIN   = DEF_CIN,
    parameter int IMG_W = DEF_IMG_W,
    parameter int IMG_H = DEF_IMG_H
) (
    input  logic               clk,
    input  logic               rst_n,
    conv_window_gen_if.slave   bus
);

    localparam int NWIN = CIN * F * F;
    localparam int PIXW = WIDTH * CIN;
    localparam int CW   = $clog2(IMG_W);
    localparam int RW   = $clog2(IMG_H);

    localparam logic [1:0] ST_FILL = FILL;
    localparam logic [1:0] ST_RUN  = RUN;
    localparam logic [1:0] ST_DONE = DONE;

    logic [1:0]       state;
    logic [CW-1:0]    col;
    logic [RW-1:0]    row;
    logic             win_valid_q;
    logic             frame_done_q;
    logic             accept;
    logic             emit;
    logic             load_win;
    logic             last_col;
    logic             last_pix;

    // chain[0] is the incoming pixel, chain[i] the same column i rows earlier.
    logic [PIXW-1:0]  chain [F];
    logic [WIDTH-1:0] shift_q [NWIN];
    logic [WIDTH-1:0] shift_d [NWIN];
    logic [WIDTH-1:0] win_q   [NWIN];

    // Single output stage: a pixel may enter whenever the held window is
    // either empty or leaving this cycle.
    assign bus.in_ready = rst_n && (state != ST_DONE) && (!win_valid_q || bus.win_ready);

    assign accept   = bus.in_valid && bus.in_ready;
    assign emit     = win_valid_q && bus.win_ready;
    assign last_col = (col == CW'(IMG_W - 1));
    assign last_pix = last_col && (row == RW'(IMG_H - 1));

    // Only windows whose F columns all come from the current row set are real;
    // the col test also masks stale line-buffer data during FILL.
    assign load_win = accept && (row >= RW'(F - 1)) && (col >= CW'(F - 1));

    assign chain[0] = bus.in_pix;

    for (genvar i = 0; i < F - 1; i++) begin : g_lb
        conv_window_gen_line_buffer #(
            .DEPTH  (IMG_W),
            .DATA_W (PIXW)
        ) u_lb (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (accept),
            .din   (chain[i]),
            .dout  (chain[i+1])
        );
    end

    // Next window contents: every column moves one left, the new right column
    // is the vertical tap stack with the oldest row at the top.
    always_comb begin
        shift_d = shift_q;
        for (int c = 0; c < CIN; c++) begin
            for (int r = 0; r < F; r++) begin
                for (int k = 0; k < F; k++) begin
                    if (k < F - 1) begin
                        shift_d[win_idx(c, r, k, F)] = shift_q[win_idx(c, r, k + 1, F)];
                    end else begin
                        shift_d[win_idx(c, r, k, F)] = chain[F-1-r][c*WIDTH +: WIDTH];
                    end
                end
            end
        end
    end

    // The shift registers need no reset; no window is flagged until F fresh
    // columns have been shifted in.
    always_ff @(posedge clk) begin
        if (accept) begin
            shift_q <= shift_d;
        end
    end

    // Output register loads the freshly shifted window, so it stays frozen
    // while the consumer stalls (no accept can happen then).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NWIN; i++) begin
                win_q[i] <= '0;
            end
        end else if (load_win) begin
            win_q <= shift_d;
        end
    end

    // Position counters, frame FSM and the output valid / frame_done flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ST_FILL;
            row          <= '0;
            col          <= '0;
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;

            if (load_win) begin
                win_valid_q <= 1'b1;
            end else if (emit) begin
                win_valid_q <= 1'b0;
            end

            if (accept) begin
                if (last_pix) begin
                    row   <= '0;
                    col   <= '0;
                    state <= ST_DONE;
                end else if (last_col) begin
                    col <= '0;
                    row <= row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end

                if (state == ST_FILL && row == RW'(F - 1) && col == '0) begin
                    state <= ST_RUN;
                end
            end

            // Frame ends once the last window has gone (or was never held).
            if (state == ST_DONE && (!win_valid_q || emit)) begin
                frame_done_q <= 1'b1;
                state        <= ST_FILL;
            end
        end
    end

    assign bus.win_valid  = win_valid_q;
    assign bus.frame_done = frame_done_q;
    assign bus.win        = win_q;

endmodule

// File: tb/tb_conv_window_gen.sv
// Directed bench for conv_window_gen on an 8x8, F=5, CIN=3 image where
// ch0 = 8*row+col, ch1 = ch0+64, ch2 = ch0+128.
module tb_conv_window_gen;

    localparam int W   = 8;
    localparam int FK  = 5;
    localparam int CI  = 3;
    localparam int IW  = 8;
    localparam int IH  = 8;
    localparam int NW  = CI * FK * FK;
    localparam int NPIX = IW * IH;
    localparam int WPR = IW - FK + 1;
    localparam int NFW = WPR * (IH - FK + 1);

    typedef struct {
        string name;
        int    win_no;
        int    entry;
        int    expected;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;

    vec_t       vecs [$];
    int         n_vec = 0;
    int         n_bad = 0;
    int         pix_idx;
    int         cap_cnt;
    int         done_cnt;
    int         first_valid_pix;
    int         cycles = 0;
    logic [7:0] cap [NFW][NW];

    always #5 clk = ~clk;

    conv_window_gen_if #(.WIDTH(W), .F(FK), .CIN(CI)) bus ();

    conv_window_gen #(
        .WIDTH (W),
        .F     (FK),
        .CIN   (CI),
        .IMG_W (IW),
        .IMG_H (IH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic logic [W*CI-1:0] pix_word(input int idx);
        logic [W*CI-1:0] p;
        for (int c = 0; c < CI; c++) begin
            p[c*W +: W] = W'(idx + 64 * c);
        end
        return p;
    endfunction

    // Window n has its top-left corner at row n/WPR, col n%WPR.
    function automatic int model_entry(input int n, input int e);
        int c, r, k;
        c = e / (FK * FK);
        r = (e % (FK * FK)) / FK;
        k = e % FK;
        return (n / WPR + r) * IW + (n % WPR + k) + 64 * c;
    endfunction

    task automatic check_output(input string name, input int actual, input int expected);
        n_vec++;
        if (actual != expected) begin
            n_bad++;
            $display("[TB] FAIL %s: actual %0d required %0d", name, actual, expected);
        end
    endtask

    // One clock: drive at the falling edge, observe what the DUT will see at
    // the next rising edge and book-keep accepts, emits and frame_done.
    task automatic apply_stimulus(input bit v, input bit r);
        @(negedge clk);
        bus.in_valid  = v && (pix_idx < NPIX);
        bus.in_pix    = pix_word((pix_idx < NPIX) ? pix_idx : 0);
        bus.win_ready = r;
        #1;
        if (bus.win_valid && first_valid_pix < 0) first_valid_pix = pix_idx;
        if (bus.win_valid && bus.win_ready) begin
            if (cap_cnt < NFW) begin
                for (int i = 0; i < NW; i++) cap[cap_cnt][i] = bus.win[i];
            end
            cap_cnt++;
        end
        if (bus.frame_done) done_cnt++;
        if (bus.in_valid && bus.in_ready) pix_idx++;
        cycles++;
    endtask

    task automatic start_frame();
        pix_idx         = 0;
        cap_cnt         = 0;
        done_cnt        = 0;
        first_valid_pix = -1;
    endtask

    task automatic run_to_end(input int v_pct, input int r_pct, input int budget);
        int start;
        start = cycles;
        while (done_cnt == 0 && (cycles - start) < budget) begin
            apply_stimulus($urandom_range(99) < v_pct, $urandom_range(99) < r_pct);
        end
        check_output("frame_done_within_budget", (done_cnt > 0) ? 1 : 0, 1);
    endtask

    task automatic compare_frame(input string tag);
        int bad;
        check_output({tag, "_window_count"}, cap_cnt, NFW);
        for (int n = 0; n < NFW; n++) begin
            bad = 0;
            if (n < cap_cnt) begin
                for (int e = 0; e < NW; e++) begin
                    if (int'(cap[n][e]) != model_entry(n, e)) bad++;
                end
            end else begin
                bad = NW;
            end
            check_output($sformatf("%s_win%0d_bad_entries", tag, n), bad, 0);
        end
    endtask

    task automatic apply_table(input string tag);
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].win_no < cap_cnt) begin
                check_output({tag, "_", vecs[i].name}, int'(cap[vecs[i].win_no][vecs[i].entry]),
                             vecs[i].expected);
            end else begin
                check_output({tag, "_", vecs[i].name}, -1, vecs[i].expected);
            end
        end
    endtask

    function automatic int nonzero_win();
        int nz;
        nz = 0;
        for (int i = 0; i < NW; i++) begin
            if (bus.win[i] != '0) nz++;
        end
        return nz;
    endfunction

    initial begin
        int guard;

        vecs.push_back('{"w0_e0",   0,  0,   0});
        vecs.push_back('{"w0_e24",  0, 24,  36});
        vecs.push_back('{"w0_e25",  0, 25,  64});
        vecs.push_back('{"w0_e74",  0, 74, 164});
        vecs.push_back('{"w1_e12",  1, 12,  19});
        vecs.push_back('{"w3_e0",   3,  0,   3});
        vecs.push_back('{"w4_e0",   4,  0,   8});
        vecs.push_back('{"w4_e24",  4, 24,  44});
        vecs.push_back('{"w5_e37",  5, 37,  91});
        vecs.push_back('{"w15_e74", 15, 74, 191});

        bus.in_valid  = 1'b0;
        bus.in_pix    = '0;
        bus.win_ready = 1'b0;
        rst_n         = 1'b0;
        start_frame();

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check_output("rst_in_ready", int'(bus.in_ready), 0);
        check_output("rst_win_valid", int'(bus.win_valid), 0);
        check_output("rst_frame_done", int'(bus.frame_done), 0);
        check_output("rst_win_zero", nonzero_win(), 0);
        rst_n = 1'b1;

        // Full-throughput stream: first window right after pixel #37
        $display("[TB] streaming frame at full rate");
        start_frame();
        run_to_end(100, 100, 300);
        check_output("first_valid_after_pix", first_valid_pix, 37);
        apply_table("t1");
        compare_frame("t1");

        // Backpressure on the first window
        $display("[TB] backpressure on first window");
        start_frame();
        guard = 0;
        while (!bus.win_valid && guard < 200) begin
            apply_stimulus(1'b1, 1'b0);
            guard++;
        end
        check_output("bp_window_appeared", int'(bus.win_valid), 1);
        check_output("bp_pix_at_stall", pix_idx, 37);
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1'b1, 1'b0);
            check_output($sformatf("bp_in_ready_%0d", i), int'(bus.in_ready), 0);
            check_output($sformatf("bp_win_valid_%0d", i), int'(bus.win_valid), 1);
            check_output($sformatf("bp_win24_%0d", i), int'(bus.win[24]), 36);
            check_output($sformatf("bp_win74_%0d", i), int'(bus.win[74]), 164);
        end
        check_output("bp_no_pixel_taken", pix_idx, 37);
        run_to_end(100, 100, 300);
        compare_frame("t3");

        // End of frame with the last window held in DONE
        $display("[TB] end of frame handling");
        start_frame();
        guard = 0;
        while (pix_idx < NPIX && guard < 300) begin
            apply_stimulus(1'b1, 1'b1);
            guard++;
        end
        check_output("eof_all_pixels_sent", pix_idx, NPIX);
        apply_stimulus(1'b0, 1'b0);
        check_output("eof_done_in_ready", int'(bus.in_ready), 0);
        check_output("eof_done_win_valid", int'(bus.win_valid), 1);
        check_output("eof_done_no_pulse_yet", int'(bus.frame_done), 0);
        apply_stimulus(1'b0, 1'b0);
        check_output("eof_done_in_ready_2", int'(bus.in_ready), 0);
        check_output("eof_last_win24_stable", int'(bus.win[24]), 63);
        apply_stimulus(1'b0, 1'b1);
        check_output("eof_no_pulse_at_emit", int'(bus.frame_done), 0);
        apply_stimulus(1'b0, 1'b1);
        check_output("eof_pulse", int'(bus.frame_done), 1);
        check_output("eof_in_ready_after", int'(bus.in_ready), 1);
        apply_stimulus(1'b0, 1'b1);
        check_output("eof_pulse_one_cycle", int'(bus.frame_done), 0);
        check_output("eof_pulse_count", done_cnt, 1);
        compare_frame("t4");

        // Next frame repeats the first-frame results
        start_frame();
        run_to_end(100, 100, 300);
        apply_table("t4b");

        // Reset in the middle of a frame
        $display("[TB] reset mid-frame");
        start_frame();
        guard = 0;
        while (pix_idx < 20 && guard < 100) begin
            apply_stimulus(1'b1, 1'b1);
            guard++;
        end
        rst_n = 1'b0;
        apply_stimulus(1'b0, 1'b1);
        check_output("mid_rst_in_ready", int'(bus.in_ready), 0);
        check_output("mid_rst_win_valid", int'(bus.win_valid), 0);
        check_output("mid_rst_frame_done", int'(bus.frame_done), 0);
        check_output("mid_rst_win_zero", nonzero_win(), 0);
        rst_n = 1'b1;
        start_frame();
        run_to_end(100, 100, 300);
        compare_frame("t5");

        // Random gaps on both sides
        $display("[TB] random valid/ready gaps");
        start_frame();
        run_to_end(50, 50, 3000);
        compare_frame("t6");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
